dram_cmd_responder: RTL and testbench

- DRAM-side endpoint of the controller's command interface; the responder for the cmd_req/cmd_ack initiator in dram_ctrl.
- Accepts one-hot bank/row/col selects plus a 2-bit command, tracks the open row per bank and enforces per-command latencies.
- Holds a bit-wide storage array (banks x rows x cols) and completes each command with a four-phase ack.
- Used as the synthesizable DRAM model in controller benches and as the command front end of the array model.

---
 rtl/dram_cmd_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_dram_cmd_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_responder.sv
// DRAM-side command responder: four-phase cmd_req/cmd_ack endpoint that
// tracks the open row of each bank, applies per-command latencies and
// holds a bit-wide banks x rows x cols storage array.
module dram_cmd_responder #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_RCD        = 3,
    parameter int T_RP         = 2,
    parameter int T_CL         = 2,
    parameter int T_WR         = 2
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    cmd_req,
    input  logic [1:0]              cmd,
    input  logic [NUM_OF_BANKS-1:0] bank_sel,
    input  logic [NUM_OF_ROWS-1:0]  row_sel,
    input  logic [NUM_OF_COLS-1:0]  col_sel,
    input  logic                    wr_data,
    output logic                    cmd_ack,
    output logic                    rd_data,
    output logic                    rd_valid,
    output logic                    proto_err,
    output logic                    busy
);

    localparam int BANK_W   = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
    localparam int ROW_W    = (NUM_OF_ROWS  > 1) ? $clog2(NUM_OF_ROWS)  : 1;
    localparam int COL_W    = (NUM_OF_COLS  > 1) ? $clog2(NUM_OF_COLS)  : 1;
    localparam int MEM_SIZE = NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS;
    localparam int ADDR_W   = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int CNT_W    = 8;

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_ACK  = 2'b10
    } state_t;

    state_t                              state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [1:0]                          cmd_q, cmd_d;
    logic [BANK_W-1:0]                   bank_q, bank_d;
    logic [ROW_W-1:0]                    row_q, row_d;
    logic [COL_W-1:0]                    col_q, col_d;
    logic                                wdat_q, wdat_d;
    logic                                sel_err_q, sel_err_d;
    logic [NUM_OF_BANKS-1:0]             bank_open_q, bank_open_d;
    logic [NUM_OF_BANKS-1:0][ROW_W-1:0]  open_row_q, open_row_d;
    logic                                ack_q, ack_d;
    logic                                rd_data_q, rd_data_d;
    logic                                rd_valid_q, rd_valid_d;
    logic                                proto_err_q, proto_err_d;

    logic                                mem_q [MEM_SIZE];
    logic                                wr_en;
    logic [ADDR_W-1:0]                   mem_addr;

    logic [BANK_W-1:0]                   bank_idx;
    logic [ROW_W-1:0]                    row_idx;
    logic [COL_W-1:0]                    col_idx;
    logic                                bank_ok, row_ok, col_ok;
    logic [CNT_W-1:0]                    lat;

    // Encode the one-hot selects and flag any select that is not exactly one-hot
    always_comb begin
        bank_idx = '0;
        row_idx  = '0;
        col_idx  = '0;
        for (int i = 0; i < NUM_OF_BANKS; i++) if (bank_sel[i]) bank_idx = BANK_W'(i);
        for (int i = 0; i < NUM_OF_ROWS; i++)  if (row_sel[i])  row_idx  = ROW_W'(i);
        for (int i = 0; i < NUM_OF_COLS; i++)  if (col_sel[i])  col_idx  = COL_W'(i);
        bank_ok = ($countones(bank_sel) == 1);
        row_ok  = ($countones(row_sel) == 1);
        col_ok  = ($countones(col_sel) == 1);
        case (cmd)
            CMD_ACT: lat = CNT_W'(T_RCD);
            CMD_RD:  lat = CNT_W'(T_CL);
            CMD_WR:  lat = CNT_W'(T_WR);
            default: lat = CNT_W'(T_RP);
        endcase
    end

    // Flat array address of the latched bank/col within that bank's open row
    always_comb begin
        mem_addr = ADDR_W'((int'(bank_q) * NUM_OF_ROWS + int'(open_row_q[bank_q]))
                           * NUM_OF_COLS + int'(col_q));
    end

    // Next-state and output logic: latch on request, count down, act, then ack
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        bank_d      = bank_q;
        row_d       = row_q;
        col_d       = col_q;
        wdat_d      = wdat_q;
        sel_err_d   = sel_err_q;
        bank_open_d = bank_open_q;
        open_row_d  = open_row_q;
        ack_d       = ack_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        proto_err_d = proto_err_q;
        wr_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_req) begin
                    cmd_d   = cmd;
                    bank_d  = bank_idx;
                    row_d   = row_idx;
                    col_d   = col_idx;
                    wdat_d  = wr_data;
                    cnt_d   = lat;
                    state_d = S_EXEC;
                    // Only the selects this command consumes are checked
                    case (cmd)
                        CMD_ACT: sel_err_d = !(bank_ok && row_ok);
                        CMD_PRE: sel_err_d = !bank_ok;
                        default: sel_err_d = !(bank_ok && col_ok);
                    endcase
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    // Counter exhausted: the action and the ack share this edge
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    if (sel_err_q) begin
                        proto_err_d = 1'b1;
                    end else begin
                        case (cmd_q)
                            CMD_ACT: begin
                                if (bank_open_q[bank_q]) begin
                                    proto_err_d = 1'b1;
                                end else begin
                                    bank_open_d[bank_q] = 1'b1;
                                    open_row_d[bank_q]  = row_q;
                                end
                            end
                            CMD_PRE: bank_open_d[bank_q] = 1'b0;
                            CMD_RD: begin
                                if (bank_open_q[bank_q]) begin
                                    rd_valid_d = 1'b1;
                                    rd_data_d  = mem_q[mem_addr];
                                end else begin
                                    proto_err_d = 1'b1;
                                end
                            end
                            default: begin
                                if (bank_open_q[bank_q]) wr_en = 1'b1;
                                else                     proto_err_d = 1'b1;
                            end
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACK: begin
                if (!cmd_req) begin
                    state_d     = S_IDLE;
                    ack_d       = 1'b0;
                    rd_data_d   = 1'b0;
                    rd_valid_d  = 1'b0;
                    proto_err_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state with synchronous active-low reset; closes every bank
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bank_open_q <= '0;
            ack_q       <= 1'b0;
            rd_data_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bank_open_q <= bank_open_d;
            ack_q       <= ack_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Latched command fields and open-row table; only meaningful while valid
    always_ff @(posedge clk) begin
        cmd_q      <= cmd_d;
        bank_q     <= bank_d;
        row_q      <= row_d;
        col_q      <= col_d;
        wdat_q     <= wdat_d;
        sel_err_q  <= sel_err_d;
        open_row_q <= open_row_d;
    end

    // Storage array write; a reset on the action edge suppresses the write
    always_ff @(posedge clk) begin
        if (rst_b && wr_en) mem_q[mem_addr] <= wdat_q;
    end

    assign cmd_ack   = ack_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign proto_err = proto_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Scoreboard bench for dram_cmd_responder: directed scenarios followed by
// randomized traffic, checked against a behavioural bank/array model.
module tb_dram_cmd_responder;

    localparam int NB = 8, NR = 128, NC = 8;
    localparam int T_RCD = 3, T_RP = 2, T_CL = 2, T_WR = 2;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          cmd_req = 1'b0;
    logic [1:0]    cmd = 2'b00;
    logic [NB-1:0] bank_sel = '0;
    logic [NR-1:0] row_sel = '0;
    logic [NC-1:0] col_sel = '0;
    logic          wr_data = 1'b0;
    logic          cmd_ack, rd_data, rd_valid, proto_err, busy;

    dram_cmd_responder #(
        .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
        .T_RCD(T_RCD), .T_RP(T_RP), .T_CL(T_CL), .T_WR(T_WR)
    ) dut (
        .clk(clk), .rst_b(rst_b), .cmd_req(cmd_req), .cmd(cmd),
        .bank_sel(bank_sel), .row_sel(row_sel), .col_sel(col_sel),
        .wr_data(wr_data), .cmd_ack(cmd_ack), .rd_data(rd_data),
        .rd_valid(rd_valid), .proto_err(proto_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit rdat;
        bit rvld;
        bit perr;
        bit chk_data;
        int ack_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Reference model state
    bit ref_open  [NB];
    int ref_row   [NB];
    bit ref_mem   [NB][NR][NC];
    bit ref_known [NB][NR][NC];

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        int r = 0;
        for (int i = 0; i < NR; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Behavioural model: decide outcome of one command and update model state
    function automatic exp_t model(input logic [1:0] c, input logic [NB-1:0] bs,
                                   input logic [NR-1:0] rs, input logic [NC-1:0] cs,
                                   input logic wd);
        exp_t e;
        int b, r, k;
        bit bok, rok, cok;
        e = '{rdat: 0, rvld: 0, perr: 0, chk_data: 1, ack_cyc: 0};
        bok = ($countones(bs) == 1);
        rok = ($countones(rs) == 1);
        cok = ($countones(cs) == 1);
        b = oh_idx({{(NR-NB){1'b0}}, bs});
        r = oh_idx(rs);
        k = oh_idx({{(NR-NC){1'b0}}, cs});
        case (c)
            2'b00: begin
                e.ack_cyc = T_RCD;
                if (!bok || !rok || ref_open[b]) e.perr = 1;
                else begin ref_open[b] = 1; ref_row[b] = r; end
            end
            2'b11: begin
                e.ack_cyc = T_RP;
                if (!bok) e.perr = 1;
                else ref_open[b] = 0;
            end
            2'b01: begin
                e.ack_cyc = T_CL;
                if (!bok || !cok || !ref_open[b]) e.perr = 1;
                else begin
                    e.rvld = 1;
                    e.rdat = ref_mem[b][ref_row[b]][k];
                    e.chk_data = ref_known[b][ref_row[b]][k];
                end
            end
            default: begin
                e.ack_cyc = T_WR;
                if (!bok || !cok || !ref_open[b]) e.perr = 1;
                else begin
                    ref_mem[b][ref_row[b]][k] = wd;
                    ref_known[b][ref_row[b]][k] = 1;
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: pops an expectation on each ack rise, checks stability while held
    exp_t cur;
    bit   prev_ack = 0;
    always @(negedge clk) begin
        if (cmd_ack && !prev_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                cur = exp_q.pop_front();
                check("ack_latency", cyc, cur.ack_cyc);
                check("proto_err", proto_err, cur.perr);
                check("rd_valid", rd_valid, cur.rvld);
                if (cur.chk_data) check("rd_data", rd_data, cur.rdat);
            end
        end else if (cmd_ack && prev_ack) begin
            check("hold_proto_err", proto_err, cur.perr);
            check("hold_rd_valid", rd_valid, cur.rvld);
            if (cur.chk_data) check("hold_rd_data", rd_data, cur.rdat);
        end else if (!cmd_ack && prev_ack) begin
            check("clear_outputs", {rd_data, rd_valid, proto_err}, 0);
        end
        prev_ack = cmd_ack;
    end

    // Issue one command through the full four-phase handshake
    task automatic issue(input logic [1:0] c, input logic [NB-1:0] bs,
                         input logic [NR-1:0] rs, input logic [NC-1:0] cs,
                         input logic wd, input int hold);
        exp_t e;
        bit got;
        e = model(c, bs, rs, cs, wd);
        e.ack_cyc = cyc + e.ack_cyc + 2;
        exp_q.push_back(e);
        cmd = c; bank_sel = bs; row_sel = rs; col_sel = cs; wr_data = wd;
        cmd_req = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (cmd_ack) got = 1;
            cmd = 2'($urandom); bank_sel = NB'($urandom);
            row_sel = {4{$urandom}}; col_sel = NC'($urandom); wr_data = 1'($urandom);
        end
        if (!got) begin
            check("ack_timeout", 0, 1);
            void'(exp_q.pop_front());
        end
        for (int i = 0; i < hold; i++) @(negedge clk);
        cmd_req = 1'b0;
        @(negedge clk);
        check("ack_fall", cmd_ack, 0);
        check("busy_idle", busy, 0);
    endtask

    function automatic logic [NR-1:0] row_oh(input int r);
        logic [NR-1:0] v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    task automatic check_reset_outputs();
        check("rst_outputs", {cmd_ack, rd_data, rd_valid, proto_err, busy}, 0);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) ref_open[i] = 0;
    endfunction

    initial begin
        int n0;
        logic [1:0] c;
        logic [NB-1:0] bs;
        logic [NR-1:0] rs;
        logic [NC-1:0] cs;

        // Reset held with a request pending: nothing may be acked
        rst_b = 1'b0;
        cmd = 2'b00; bank_sel = 8'b0000_1000; row_sel = row_oh(77); cmd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_reset_outputs();
        end
        rst_b = 1'b1;
        issue(2'b00, 8'b0000_1000, row_oh(77), 8'h00, 1'b0, 0);

        // Write, close, reopen, read back
        issue(2'b10, 8'b0000_1000, row_oh(3), 8'b0010_0000, 1'b1, 1);
        issue(2'b11, 8'b0000_1000, '0, 8'hff, 1'b0, 0);
        issue(2'b00, 8'b0000_1000, row_oh(77), 8'h00, 1'b0, 0);
        issue(2'b01, 8'b0000_1000, row_oh(9), 8'b0010_0000, 1'b0, 10);

        // Closed-bank read, double activate, read from first row
        issue(2'b01, 8'b0000_0100, '0, 8'b0000_0010, 1'b0, 0);
        issue(2'b00, 8'b0000_0100, row_oh(10), 8'h00, 1'b0, 0);
        issue(2'b00, 8'b0000_0100, row_oh(20), 8'h00, 1'b0, 0);
        issue(2'b10, 8'b0000_0100, '0, 8'b0000_0010, 1'b1, 0);
        issue(2'b01, 8'b0000_0100, '0, 8'b0000_0010, 1'b0, 2);

        // Malformed bank select on write, read-back, PRE on closed bank
        issue(2'b10, 8'b0000_0110, '0, 8'b0010_0000, 1'b0, 0);
        issue(2'b01, 8'b0000_1000, '0, 8'b0010_0000, 1'b0, 0);
        issue(2'b10, 8'b0000_1000, '0, 8'b0000_0000, 1'b0, 0);
        issue(2'b11, 8'b0010_0000, '0, 8'h00, 1'b0, 0);

        // Reset in the middle of a write's execution
        n0 = cyc;
        cmd = 2'b10; bank_sel = 8'b0000_1000; col_sel = 8'b0010_0000; wr_data = 1'b0;
        cmd_req = 1'b1;
        while (cyc < n0 + 2) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        cmd_req = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        model_reset();
        rst_b = 1'b1;
        @(negedge clk);
        issue(2'b01, 8'b0000_1000, '0, 8'b0010_0000, 1'b0, 0);
        issue(2'b00, 8'b0000_1000, row_oh(77), 8'h00, 1'b0, 0);
        issue(2'b01, 8'b0000_1000, '0, 8'b0010_0000, 1'b0, 0);

        // Randomized traffic over a small bank/row footprint
        for (int n = 0; n < 150; n++) begin
            c  = 2'($urandom);
            bs = NB'(1) << $urandom_range(0, 3);
            rs = row_oh($urandom_range(0, 3));
            cs = NC'(1) << $urandom_range(0, 7);
            if ($urandom_range(0, 9) == 0) bs = ($urandom_range(0, 1) != 0) ? '0 : (bs | 8'h80);
            if ($urandom_range(0, 9) == 0) cs = ($urandom_range(0, 1) != 0) ? '0 : (cs | 8'h01);
            if ($urandom_range(0, 11) == 0) rs = '0;
            if (c == 2'b00) cs = NC'($urandom);
            else rs = {4{$urandom}};
            if (c == 2'b11) cs = NC'($urandom);
            issue(c, bs, rs, cs, 1'($urandom), $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
